i2c_target_regfile: RTL and testbench

Parametrised I2C target with its own protocol state machine and a byte-wide register file. Samples asynchronous SCL/SDA pins on the system clock, detects START/STOP/repeated START, matches a configurable 7-bit address, and services pointer-then-data writes and auto-incrementing reads. Register 0 is a read-only status register loaded from a parallel input. The register file is exported packed to the rest of the chip.

---
 rtl/i2c_target_regfile.sv | 208 ++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file, pointer-then-data writes and auto-incrementing reads.
// Optional feature: define I2C_GENERAL_CALL_EN to ACK the general-call write address 0x00.
module i2c_target_regfile #(
    parameter logic [6:0] ADDR      = 7'h20,
    parameter int         REG_COUNT = 32,
    parameter int         PTR_W     = $clog2(REG_COUNT)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   SCL,
    input  logic                   SDA_in,
    output logic                   SDA_out,
    input  logic [7:0]             parallel_in,
    output logic [8*REG_COUNT-1:0] registers_packed,
    // wr_strobe is a valid-only pulse with no ready: wr_addr is meaningful only in the strobe cycle.
    output logic                   wr_strobe,
    output logic [PTR_W-1:0]       wr_addr,
    output logic                   busy
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_IGNORE
    } state_t;

    state_t           state;
    logic             scl_s1, scl_s2, scl_q, sda_s1, sda_s2, sda_q;
    logic             scl_rise, scl_fall, sda_rise, sda_fall;
    logic [3:0]       bit_cnt;
    logic [7:0]       shift;
    logic [PTR_W-1:0] ptr;
    logic             rw;
    logic             ack_phase;
    logic [7:0]       regs [REG_COUNT];

    logic             start_cond, stop_cond, last_bit;
    logic [7:0]       byte_in;
    logic             addr_match, gc_match, ptr_ok;
    logic [PTR_W-1:0] ptr_next_wr, ptr_next_rd;

    always_ff @(posedge clock) begin
        if (reset) begin
            scl_s1   <= 1'b0;
            scl_s2   <= 1'b0;
            scl_q    <= 1'b0;
            sda_s1   <= 1'b0;
            sda_s2   <= 1'b0;
            sda_q    <= 1'b0;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            sda_rise <= 1'b0;
            sda_fall <= 1'b0;
        end else begin
            scl_s1   <= SCL;
            scl_s2   <= scl_s1;
            scl_q    <= scl_s2;
            sda_s1   <= SDA_in;
            sda_s2   <= sda_s1;
            sda_q    <= sda_s2;
            scl_rise <= scl_s2 & ~scl_q;
            scl_fall <= ~scl_s2 & scl_q;
            sda_rise <= sda_s2 & ~sda_q;
            sda_fall <= ~sda_s2 & sda_q;
        end
    end

    // scl_q holds the SCL level that the registered SDA edge was detected against.
    assign start_cond  = sda_fall & scl_q;
    assign stop_cond   = sda_rise & scl_q;
    assign byte_in     = {shift[6:0], sda_q};
    assign last_bit    = scl_rise && (bit_cnt == 4'd7);
    assign addr_match  = (byte_in[7:1] == ADDR);
    assign ptr_ok      = ({1'b0, byte_in} < 9'(REG_COUNT));
    assign ptr_next_wr = (ptr == PTR_W'(REG_COUNT - 1)) ? PTR_W'(1) : ptr + PTR_W'(1);
    assign ptr_next_rd = (ptr == PTR_W'(REG_COUNT - 1)) ? '0 : ptr + PTR_W'(1);

`ifdef I2C_GENERAL_CALL_EN
    assign gc_match = (byte_in == 8'h00);
`else
    assign gc_match = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            ptr       <= '0;
            rw        <= 1'b0;
            ack_phase <= 1'b0;
            SDA_out   <= 1'b1;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            busy      <= 1'b0;
            for (int j = 0; j < REG_COUNT; j++) regs[j] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (start_cond) begin
                state     <= ST_ADDR;
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
                SDA_out   <= 1'b1;
            end else if (stop_cond) begin
                state     <= ST_IDLE;
                ack_phase <= 1'b0;
                SDA_out   <= 1'b1;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: if (scl_rise) begin
                        shift   <= byte_in;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (last_bit) begin
                            if (addr_match || gc_match) begin
                                rw        <= byte_in[0];
                                busy      <= 1'b1;
                                ack_phase <= 1'b0;
                                state     <= ST_ADDR_ACK;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end
                    // First fall after the byte pulls SDA low, the next one ends the ACK slot.
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
                        if (!ack_phase) begin
                            SDA_out   <= 1'b0;
                            ack_phase <= 1'b1;
                        end else begin
                            ack_phase <= 1'b0;
                            bit_cnt   <= '0;
                            if (state == ST_ADDR_ACK && rw) begin
                                state   <= ST_RDATA;
                                shift   <= regs[ptr];
                                SDA_out <= regs[ptr][7];
                            end else begin
                                SDA_out <= 1'b1;
                                state   <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                            end
                        end
                    end
                    ST_PTR: if (scl_rise) begin
                        shift   <= byte_in;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (last_bit) begin
                            if (ptr_ok) begin
                                ptr   <= byte_in[PTR_W-1:0];
                                state <= ST_PTR_ACK;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_WDATA: if (scl_rise) begin
                        shift   <= byte_in;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (last_bit) begin
                            if (ptr != '0) begin
                                regs[ptr] <= byte_in;
                                wr_strobe <= 1'b1;
                                wr_addr   <= ptr;
                                ptr       <= ptr_next_wr;
                            end
                            state <= ST_WDATA_ACK;
                        end
                    end
                    ST_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                SDA_out   <= 1'b1;
                                ack_phase <= 1'b0;
                                state     <= ST_RDATA_ACK;
                            end else begin
                                SDA_out <= shift[6];
                                shift   <= {shift[6:0], 1'b0};
                            end
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (scl_rise && !ack_phase) begin
                            if (!sda_q) begin
                                ptr       <= ptr_next_rd;
                                ack_phase <= 1'b1;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end else if (scl_fall && ack_phase) begin
                            ack_phase <= 1'b0;
                            bit_cnt   <= '0;
                            state     <= ST_RDATA;
                            shift     <= regs[ptr];
                            SDA_out   <= regs[ptr][7];
                        end
                    end
                    default: ;
                endcase
            end
            regs[0] <= parallel_in;
        end
    end

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_pack
        assign registers_packed[8*g +: 8] = regs[g];
    end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: a bit-banged master on a wired-AND SDA bus.
module tb_i2c_target_regfile;

    localparam int REG_COUNT = 32;
    localparam int PTR_W     = 5;
    localparam int Q         = 8;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   scl;
    logic                   sda_m;
    logic                   SDA_out;
    logic [7:0]             parallel_in;
    logic [8*REG_COUNT-1:0] registers_packed;
    logic                   wr_strobe;
    logic [PTR_W-1:0]       wr_addr;
    logic                   busy;
    wire                    sda_bus = sda_m & SDA_out;

    int          n_checks = 0;
    int          n_errors = 0;
    int          sda_low_total = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    always #5 clock = ~clock;

    i2c_target_regfile #(.ADDR(7'h20), .REG_COUNT(REG_COUNT)) dut (
        .clock(clock), .reset(reset), .SCL(scl), .SDA_in(sda_bus), .SDA_out(SDA_out),
        .parallel_in(parallel_in), .registers_packed(registers_packed),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .busy(busy)
    );

    always @(negedge clock) begin
        if (!SDA_out) sda_low_total++;
        if (wr_strobe) got_q.push_back({3'b000, wr_addr, registers_packed[8*wr_addr +: 8]});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] reg_at(input int j);
        return registers_packed[8*j +: 8];
    endfunction

    task automatic check_strobes(input string tag);
        check({tag, "_wr_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_wr"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clock);
    endtask

    task automatic i2c_start();
        sda_m = 1'b0; wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; wait_q();
        scl = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; wait_q();
        scl = 1'b1; wait_q(); wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wait_q();
        scl = 1'b1; wait_q();
        b = sda_bus; wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic master_ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(!master_ack);
    endtask

    initial begin
        logic       a;
        logic [7:0] d;
        int         low0;

        reset = 1'b1; scl = 1'b1; sda_m = 1'b1; parallel_in = 8'h00;
        repeat (4) @(negedge clock);
        check("rst_sda_out", SDA_out, 1);
        check("rst_busy", busy, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_regs", |registers_packed, 0);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // Plain write with auto-increment
        exp_q.push_back({8'd5, 8'hA5});
        exp_q.push_back({8'd6, 8'h3C});
        i2c_start();
        send_byte(8'h40, a); check("wr_addr_ack", a, 0);
        send_byte(8'h05, a); check("wr_ptr_ack", a, 0);
        send_byte(8'hA5, a); check("wr_d0_ack", a, 0);
        send_byte(8'h3C, a); check("wr_d1_ack", a, 0);
        check("wr_busy_high", busy, 1);
        i2c_stop();
        check("wr_busy_low", busy, 0);
        check("wr_reg5", reg_at(5), 8'hA5);
        check("wr_reg6", reg_at(6), 8'h3C);
        check_strobes("wr");

        // Pointer write, repeated START, read two bytes
        i2c_start();
        send_byte(8'h40, a); check("rd_waddr_ack", a, 0);
        send_byte(8'h06, a); check("rd_ptr_ack", a, 0);
        i2c_rstart();
        send_byte(8'h41, a); check("rd_raddr_ack", a, 0);
        read_byte(d, 1'b1); check("rd_byte0", d, 8'h3C);
        read_byte(d, 1'b0); check("rd_byte1", d, 8'h00);
        low0 = sda_low_total;
        wait_q();
        i2c_stop();
        check("rd_released_after_nack", sda_low_total - low0, 0);
        check("rd_busy_low", busy, 0);
        check_strobes("rd");

        // Foreign address, then out-of-range pointer
        low0 = sda_low_total;
        i2c_start();
        send_byte(8'h42, a); check("foreign_nack", a, 1);
        check("foreign_never_low", sda_low_total - low0, 0);
        check("foreign_busy", busy, 0);
        i2c_stop();
        i2c_start();
        send_byte(8'h40, a); check("oor_addr_ack", a, 0);
        send_byte(8'h20, a); check("oor_ptr_nack", a, 1);
        i2c_stop();
        check_strobes("oor");

        // Read-only register 0 and pointer wrap
        parallel_in = 8'h5A;
        wait_q();
        i2c_start();
        send_byte(8'h40, a); check("ro_addr_ack", a, 0);
        send_byte(8'h00, a); check("ro_ptr_ack", a, 0);
        send_byte(8'h11, a); check("ro_data_ack", a, 0);
        i2c_stop();
        check("ro_reg0", reg_at(0), 8'h5A);
        check_strobes("ro");
        exp_q.push_back({8'd31, 8'h77});
        exp_q.push_back({8'd1, 8'h88});
        i2c_start();
        send_byte(8'h40, a); check("wrap_addr_ack", a, 0);
        send_byte(8'h1F, a); check("wrap_ptr_ack", a, 0);
        send_byte(8'h77, a); check("wrap_d0_ack", a, 0);
        send_byte(8'h88, a); check("wrap_d1_ack", a, 0);
        i2c_stop();
        check("wrap_reg31", reg_at(31), 8'h77);
        check("wrap_reg1", reg_at(1), 8'h88);
        check_strobes("wrap");
        i2c_start();
        send_byte(8'h40, a);
        send_byte(8'h1F, a);
        i2c_rstart();
        send_byte(8'h41, a); check("rwrap_addr_ack", a, 0);
        read_byte(d, 1'b1); check("rwrap_reg31", d, 8'h77);
        read_byte(d, 1'b0); check("rwrap_reg0", d, 8'h5A);
        i2c_stop();

        // Reset during bit 3 of a read (pointer is 0, byte 0x5A, third bit is 0)
        i2c_start();
        send_byte(8'h41, a); check("mrst_addr_ack", a, 0);
        recv_bit(a); check("mrst_bit7", a, 0);
        recv_bit(a); check("mrst_bit6", a, 1);
        sda_m = 1'b1; wait_q();
        scl = 1'b1; wait_q();
        check("mrst_driving_low", SDA_out, 0);
        check("mrst_busy_before", busy, 1);
        reset = 1'b1;
        @(negedge clock);
        check("mrst_sda_out", SDA_out, 1);
        check("mrst_busy", busy, 0);
        check("mrst_wr_strobe", wr_strobe, 0);
        check("mrst_wr_addr", wr_addr, 0);
        check("mrst_regs", |registers_packed, 0);
        reset = 1'b0;
        wait_q();
        scl = 1'b0; wait_q();
        i2c_stop();
        check("mrst_reg0_reload", reg_at(0), 8'h5A);
        exp_q.push_back({8'd3, 8'hC3});
        i2c_start();
        send_byte(8'h40, a); check("post_addr_ack", a, 0);
        send_byte(8'h03, a); check("post_ptr_ack", a, 0);
        send_byte(8'hC3, a); check("post_data_ack", a, 0);
        i2c_stop();
        check("post_reg3", reg_at(3), 8'hC3);
        check_strobes("post");

        // General call address
        i2c_start();
`ifdef I2C_GENERAL_CALL_EN
        exp_q.push_back({8'd2, 8'h99});
        send_byte(8'h00, a); check("gc_addr_ack", a, 0);
        send_byte(8'h02, a); check("gc_ptr_ack", a, 0);
        send_byte(8'h99, a); check("gc_data_ack", a, 0);
        i2c_stop();
        check("gc_reg2", reg_at(2), 8'h99);
`else
        send_byte(8'h00, a); check("gc_addr_nack", a, 1);
        send_byte(8'h02, a); check("gc_ptr_nack", a, 1);
        send_byte(8'h99, a); check("gc_data_nack", a, 1);
        i2c_stop();
        check("gc_reg2", reg_at(2), 8'h00);
`endif
        check_strobes("gc");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
